// File: rtl/rtc_alrm_sched.sv
// RTC alarm scheduler: one-shot alarm slots with pending/irq flags and a
// sequential scan that reports the armed slot whose alarm comes up soonest.
module rtc_alrm_sched #(
  parameter int NUM_SLOT  = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [CNT_WIDTH-1:0]        cnt_i,
  input  logic                        cnt_tick_i,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [$clog2(NUM_SLOT)-1:0] wr_slot_i,
  input  logic                        wr_arm_i,
  input  logic [CNT_WIDTH-1:0]        wr_alrm_i,
  input  logic [NUM_SLOT-1:0]         ie_i,
  input  logic [NUM_SLOT-1:0]         clr_i,
  output logic [NUM_SLOT-1:0]         pend_o,
  output logic [NUM_SLOT-1:0]         arm_o,
  output logic                        busy_o,
  output logic                        nxt_vld_o,
  output logic [$clog2(NUM_SLOT)-1:0] nxt_slot_o,
  output logic [CNT_WIDTH-1:0]        nxt_alrm_o,
  output logic                        irq_o
);

  localparam int SW = $clog2(NUM_SLOT);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] alrm_q [NUM_SLOT];
  logic [NUM_SLOT-1:0]  arm_q, pend_q;
  logic [NUM_SLOT-1:0]  hit, wsel;
  logic                 wr_acc;
  logic                 rescan_q, rescan_d;
  logic [SW-1:0]        idx_q, idx_d;
  logic                 last;

  logic                 best_vld_q, best_vld_d;
  logic [CNT_WIDTH-1:0] best_dist_q, best_dist_d;
  logic [SW-1:0]        best_slot_q, best_slot_d;
  logic [CNT_WIDTH-1:0] best_alrm_q, best_alrm_d;

  logic [CNT_WIDTH-1:0] cand_alrm, cand_dist;
  logic                 take;
  logic                 nxt_upd;

  assign busy_o     = (state_q == SCAN);
  assign wr_ready_o = ~busy_o;
  assign wr_acc     = wr_valid_i && wr_ready_o;
  assign pend_o     = pend_q;
  assign arm_o      = arm_q;
  assign irq_o      = |(pend_q & ie_i);

  always_comb begin
    hit  = '0;
    wsel = '0;
    for (int i = 0; i < NUM_SLOT; i++) begin
      hit[i]  = cnt_tick_i && arm_q[i] && (alrm_q[i] == cnt_i);
      wsel[i] = wr_acc && (wr_slot_i == SW'(i));
    end
  end

  // A write owns its slot this cycle: no pend set, no disarm by the hit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      arm_q  <= '0;
      pend_q <= '0;
      for (int i = 0; i < NUM_SLOT; i++) alrm_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOT; i++) begin
        if (wsel[i]) begin
          arm_q[i]  <= wr_arm_i;
          alrm_q[i] <= wr_alrm_i;
        end else if (hit[i]) begin
          arm_q[i]  <= 1'b0;
        end
        if (hit[i] && !wsel[i]) pend_q[i] <= 1'b1;
        else if (clr_i[i])      pend_q[i] <= 1'b0;
      end
    end
  end

  assign cand_alrm = alrm_q[idx_q];
  assign cand_dist = cand_alrm - cnt_i;
  assign last      = (idx_q == SW'(NUM_SLOT - 1));
  assign take      = arm_q[idx_q] &&
                     (!best_vld_q || (cand_dist < best_dist_q));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rescan_d    = rescan_q;
    best_vld_d  = best_vld_q;
    best_dist_d = best_dist_q;
    best_slot_d = best_slot_q;
    best_alrm_d = best_alrm_q;
    nxt_upd     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_acc || (|hit) || rescan_q) begin
          state_d     = SCAN;
          idx_d       = '0;
          rescan_d    = 1'b0;
          best_vld_d  = 1'b0;
          best_dist_d = '0;
          best_slot_d = '0;
          best_alrm_d = '0;
        end
      end
      SCAN: begin
        if (|hit) rescan_d = 1'b1;
        if (take) begin
          best_vld_d  = 1'b1;
          best_dist_d = cand_dist;
          best_slot_d = idx_q;
          best_alrm_d = cand_alrm;
        end
        idx_d = idx_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          idx_d   = '0;
          nxt_upd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rescan_q    <= 1'b0;
      best_vld_q  <= 1'b0;
      best_dist_q <= '0;
      best_slot_q <= '0;
      best_alrm_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rescan_q    <= rescan_d;
      best_vld_q  <= best_vld_d;
      best_dist_q <= best_dist_d;
      best_slot_q <= best_slot_d;
      best_alrm_q <= best_alrm_d;
    end
  end

  // Published result only moves on the SCAN->IDLE edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      nxt_vld_o  <= 1'b0;
      nxt_slot_o <= '0;
      nxt_alrm_o <= '0;
    end else if (nxt_upd) begin
      nxt_vld_o  <= best_vld_d;
      nxt_slot_o <= best_slot_d;
      nxt_alrm_o <= best_alrm_d;
    end
  end

endmodule

// File: tb/tb_rtc_alrm_sched.sv
// Directed bench for rtc_alrm_sched: programming, hits, wrap-around ranking,
// write/hit collisions, rescan and asynchronous reset mid-scan.
module tb_rtc_alrm_sched;

  logic        clk;
  logic        rst_n;
  logic [31:0] cnt;
  logic        tick;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_slot;
  logic        wr_arm;
  logic [31:0] wr_alrm;
  logic [3:0]  ie;
  logic [3:0]  clr;
  logic [3:0]  pend;
  logic [3:0]  arm;
  logic        busy;
  logic        nxt_vld;
  logic [1:0]  nxt_slot;
  logic [31:0] nxt_alrm;
  logic        irq;

  int tests;
  int fails;

  rtc_alrm_sched #(
    .NUM_SLOT (4),
    .CNT_WIDTH(32)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .cnt_i     (cnt),
    .cnt_tick_i(tick),
    .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready),
    .wr_slot_i (wr_slot),
    .wr_arm_i  (wr_arm),
    .wr_alrm_i (wr_alrm),
    .ie_i      (ie),
    .clr_i     (clr),
    .pend_o    (pend),
    .arm_o     (arm),
    .busy_o    (busy),
    .nxt_vld_o (nxt_vld),
    .nxt_slot_o(nxt_slot),
    .nxt_alrm_o(nxt_alrm),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] s, input logic a,
                          input logic [31:0] v);
    wr_valid = 1'b1;
    wr_slot  = s;
    wr_arm   = a;
    wr_alrm  = v;
    step(1);
    wr_valid = 1'b0;
    step(4);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    cnt = 32'd10;
    tick = 1'b0;
    wr_valid = 1'b0;
    wr_slot = 2'd0;
    wr_arm = 1'b0;
    wr_alrm = 32'd0;
    ie = 4'b0010;
    clr = 4'b0000;
    step(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_vld", 32'(nxt_vld), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_arm", 32'(arm), 32'd0);
    rst_n = 1'b1;
    step(1);

    // slot2=100 accepted, then slot1 held valid through the scan
    wr_valid = 1'b1;
    wr_slot  = 2'd2;
    wr_arm   = 1'b1;
    wr_alrm  = 32'd100;
    step(1);
    wr_slot  = 2'd1;
    wr_alrm  = 32'd50;
    check("arm_s2", 32'(arm), 32'b0100);
    for (int k = 0; k < 4; k++) begin
      check("ready_low_scan", 32'(wr_ready), 32'd0);
      step(1);
    end
    check("ready_back", 32'(wr_ready), 32'd1);
    check("scan1_slot", 32'(nxt_slot), 32'd2);
    check("scan1_alrm", nxt_alrm, 32'd100);
    check("arm_before_s1", 32'(arm), 32'b0100);
    step(1);
    wr_valid = 1'b0;
    check("s1_accepted", 32'(arm), 32'b0110);
    check("busy_s1", 32'(busy), 32'd1);
    step(2);
    check("hold_slot", 32'(nxt_slot), 32'd2);
    step(2);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_vld", 32'(nxt_vld), 32'd1);
    check("t1_slot", 32'(nxt_slot), 32'd1);
    check("t1_alrm", nxt_alrm, 32'd50);

    // hit slot1 at cnt=50
    cnt  = 32'd50;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("t2_pend", 32'(pend), 32'b0010);
    check("t2_arm", 32'(arm), 32'b0100);
    check("t2_irq", 32'(irq), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    step(4);
    check("t2_slot", 32'(nxt_slot), 32'd2);
    check("t2_alrm", nxt_alrm, 32'd100);
    clr = 4'b0010;
    step(1);
    clr = 4'b0000;
    check("t2_clr", 32'(pend), 32'd0);
    check("t2_irq0", 32'(irq), 32'd0);

    // wrap-around ranking
    cnt = 32'hFFFF_FFF0;
    do_write(2'd0, 1'b1, 32'd5);
    check("t3_s0", 32'(nxt_slot), 32'd0);
    do_write(2'd3, 1'b1, 32'hFFFF_FFF8);
    check("t3_slot", 32'(nxt_slot), 32'd3);
    check("t3_alrm", nxt_alrm, 32'hFFFF_FFF8);
    cnt  = 32'hFFFF_FFF8;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("t3_pend", 32'(pend), 32'b1000);
    check("t3_irq_masked", 32'(irq), 32'd0);
    step(4);
    check("t3_wrap_slot", 32'(nxt_slot), 32'd0);
    check("t3_wrap_alrm", nxt_alrm, 32'd5);
    cnt = 32'hFFFF_FFFF;
    do_write(2'd1, 1'b1, 32'd0);
    check("t3_dist1_slot", 32'(nxt_slot), 32'd1);
    check("t3_dist1_alrm", nxt_alrm, 32'd0);

    // simultaneous hits, then write colliding with a hit
    cnt = 32'd60;
    do_write(2'd0, 1'b1, 32'd70);
    do_write(2'd2, 1'b1, 32'd70);
    do_write(2'd1, 1'b0, 32'd0);
    clr = 4'b1000;
    step(1);
    clr = 4'b0000;
    check("t4_pre_arm", 32'(arm), 32'b0101);
    check("t4_pre_pend", 32'(pend), 32'd0);
    cnt  = 32'd70;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("t4_both_pend", 32'(pend), 32'b0101);
    check("t4_both_arm", 32'(arm), 32'd0);
    step(4);
    check("t4_none_vld", 32'(nxt_vld), 32'd0);
    check("t4_none_slot", 32'(nxt_slot), 32'd0);
    check("t4_none_alrm", nxt_alrm, 32'd0);
    clr = 4'b0101;
    step(1);
    clr = 4'b0000;
    do_write(2'd0, 1'b1, 32'd70);
    do_write(2'd2, 1'b1, 32'd70);
    tick     = 1'b1;
    wr_valid = 1'b1;
    wr_slot  = 2'd0;
    wr_arm   = 1'b1;
    wr_alrm  = 32'd200;
    step(1);
    tick     = 1'b0;
    wr_valid = 1'b0;
    check("t4_wr_pend", 32'(pend), 32'b0100);
    check("t4_wr_arm", 32'(arm), 32'b0001);
    step(4);
    check("t4_wr_slot", 32'(nxt_slot), 32'd0);
    check("t4_wr_alrm", nxt_alrm, 32'd200);

    // hit during scan triggers a rescan
    do_write(2'd1, 1'b1, 32'd80);
    check("t5_pre_slot", 32'(nxt_slot), 32'd1);
    cnt  = 32'd80;
    tick = 1'b1;
    step(1);
    cnt = 32'd200;
    step(1);
    tick = 1'b0;
    check("t5_pend", 32'(pend), 32'b0111);
    check("t5_arm", 32'(arm), 32'd0);
    step(3);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_slot", 32'(nxt_slot), 32'd0);
    check("t5_alrm", nxt_alrm, 32'd200);
    step(1);
    check("t5_rescan", 32'(busy), 32'd1);
    step(4);
    check("t5_done", 32'(busy), 32'd0);
    check("t5_vld", 32'(nxt_vld), 32'd0);

    // asynchronous reset mid-scan
    wr_valid = 1'b1;
    wr_slot  = 2'd1;
    wr_arm   = 1'b1;
    wr_alrm  = 32'd300;
    step(1);
    wr_valid = 1'b0;
    step(1);
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_irq", 32'(irq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(wr_ready), 32'd1);
    check("t6_rst_vld", 32'(nxt_vld), 32'd0);
    check("t6_rst_slot", 32'(nxt_slot), 32'd0);
    check("t6_rst_alrm", nxt_alrm, 32'd0);
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_arm", 32'(arm), 32'd0);
    check("t6_rst_pend", 32'(pend), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(5);
    check("t6_post_busy", 32'(busy), 32'd0);
    check("t6_post_vld", 32'(nxt_vld), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
